itrx_aib_phy_io_buf_ctl: RTL and testbench

Digital transmit/direction controller for one AIB IO buffer. It sits on the core side of the IO buffer and generates the pad-control inputs: `txdat_mux`, `tx_en_buf`, `ipdrv`, `indrv`, `weakp0`, `weakp1`, `rx_dat_en` and `rx_clk_en`. A registered sequencer turns mode requests into break-before-make pad transitions with programmable guard intervals. It forces the pad to a safe state during reset and POR.

---
 rtl/itrx_aib_phy_io_buf_ctl_pkg.sv | 36 +++
 rtl/itrx_aib_phy_sync2.sv | 22 ++
 rtl/itrx_aib_phy_io_buf_ctl.sv | 168 ++++++++++++++++
 tb/tb_itrx_aib_phy_io_buf_ctl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_io_buf_ctl_pkg.sv
// rtl/itrx_aib_phy_io_buf_ctl_pkg.sv - mode/state encodings and pad-control constants for the AIB IO buffer controller
package itrx_aib_phy_io_buf_ctl_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_RX  = 2'b01;
    localparam logic [1:0] MODE_TX  = 2'b10;

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_RX      = 3'd1;
    localparam logic [2:0] ST_TX_ARM  = 3'd2;
    localparam logic [2:0] ST_TX      = 3'd3;
    localparam logic [2:0] ST_QUIESCE = 3'd4;

    typedef struct packed {
        logic       txdat_mux;
        logic       tx_en_buf;
        logic [1:0] ipdrv;
        logic [1:0] indrv;
        logic       weakp1;
        logic       weakp0;
        logic       rx_dat_en;
        logic       rx_clk_en;
    } pad_ctl_t;

    // Pad held quiet with a weak pull-down while reset or POR is active
    localparam pad_ctl_t PAD_SAFE = '{
        txdat_mux: 1'b0, tx_en_buf: 1'b0, ipdrv: 2'b00, indrv: 2'b00,
        weakp1: 1'b0, weakp0: 1'b1, rx_dat_en: 1'b0, rx_clk_en: 1'b0
    };

    // Returns {weakp1, weakp0}; pull-down wins when both are requested
    function automatic logic [1:0] weak_pulls(input logic wkpu, input logic wkpd);
        return {wkpu & ~wkpd, wkpd};
    endfunction

endpackage

// File: rtl/itrx_aib_phy_sync2.sv
// rtl/itrx_aib_phy_sync2.sv - two-flop synchronizer with programmable reset value
module itrx_aib_phy_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q1,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/itrx_aib_phy_io_buf_ctl.sv
// rtl/itrx_aib_phy_io_buf_ctl.sv - break-before-make TX/RX direction sequencer for one AIB IO buffer
module itrx_aib_phy_io_buf_ctl
    import itrx_aib_phy_io_buf_ctl_pkg::*;
#(
    parameter int unsigned GUARD   = 4,
    parameter bit          CLK_PIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       por,
    input  logic [1:0] mode_req,
    input  logic       tx_data,
    input  logic [1:0] cfg_pdrv,
    input  logic [1:0] cfg_ndrv,
    input  logic       cfg_wkpu,
    input  logic       cfg_wkpd,
    output logic       txdat_mux,
    output logic       tx_en_buf,
    output logic [1:0] ipdrv,
    output logic [1:0] indrv,
    output logic       weakp1,
    output logic       weakp0,
    output logic       rx_dat_en,
    output logic       rx_clk_en,
    output logic [1:0] mode_ack,
    output logic       busy
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

    logic       por_s1;
    logic       por_s;
    logic       hold_safe;
    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       load_drv;
    pad_ctl_t   pad_q;
    pad_ctl_t   pad_nxt;
    logic [1:0] mode_ack_nxt;
    logic       busy_nxt;

    itrx_aib_phy_sync2 #(.RST_VAL(1'b1)) u_por_sync (
        .clk (clk),
        .rst (rst),
        .d   (por),
        .q1  (por_s1),
        .q   (por_s)
    );

    // Enter the safe state on the first synchronized POR sample, but release
    // only once both stages have cleared.
    assign hold_safe = por_s | por_s1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_drv  = 1'b0;
        if (hold_safe) begin
            state_nxt = ST_OFF;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (mode_req == MODE_RX) begin
                        state_nxt = ST_RX;
                    end else if (mode_req == MODE_TX) begin
                        state_nxt = ST_TX_ARM;
                        cnt_nxt   = GUARD_LOAD;
                        load_drv  = 1'b1;
                    end
                end
                ST_RX: begin
                    if (mode_req != MODE_RX) state_nxt = ST_OFF;
                end
                ST_TX_ARM: begin
                    if (mode_req != MODE_TX) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = 4'd0;
                    end else if (cnt == 4'd0) begin
                        state_nxt = ST_TX;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                ST_TX: begin
                    if (mode_req != MODE_TX) begin
                        state_nxt = ST_QUIESCE;
                        cnt_nxt   = GUARD_LOAD;
                    end
                end
                ST_QUIESCE: begin
                    if (cnt == 4'd0) state_nxt = ST_OFF;
                    else             cnt_nxt   = cnt - 4'd1;
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Outputs are built from the next state so pads move on the state edge
    always_comb begin
        pad_nxt = PAD_SAFE;
        {pad_nxt.weakp1, pad_nxt.weakp0} = weak_pulls(cfg_wkpu, cfg_wkpd);
        mode_ack_nxt = MODE_OFF;
        busy_nxt     = 1'b0;
        case (state_nxt)
            ST_RX: begin
                mode_ack_nxt = MODE_RX;
                if (CLK_PIN) pad_nxt.rx_clk_en = 1'b1;
                else         pad_nxt.rx_dat_en = 1'b1;
            end
            ST_TX_ARM: begin
                busy_nxt      = 1'b1;
                pad_nxt.ipdrv = load_drv ? cfg_pdrv : pad_q.ipdrv;
                pad_nxt.indrv = load_drv ? cfg_ndrv : pad_q.indrv;
            end
            ST_TX: begin
                mode_ack_nxt      = MODE_TX;
                pad_nxt.tx_en_buf = 1'b1;
                pad_nxt.txdat_mux = tx_data;
                pad_nxt.ipdrv     = pad_q.ipdrv;
                pad_nxt.indrv     = pad_q.indrv;
                pad_nxt.weakp1    = 1'b0;
                pad_nxt.weakp0    = 1'b0;
            end
            ST_QUIESCE: begin
                busy_nxt      = 1'b1;
                pad_nxt.ipdrv = pad_q.ipdrv;
                pad_nxt.indrv = pad_q.indrv;
            end
            default: ;
        endcase
        if (hold_safe) begin
            pad_nxt = PAD_SAFE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            cnt      <= 4'd0;
            pad_q    <= PAD_SAFE;
            mode_ack <= MODE_OFF;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pad_q    <= pad_nxt;
            mode_ack <= mode_ack_nxt;
            busy     <= busy_nxt;
        end
    end

    assign txdat_mux = pad_q.txdat_mux;
    assign tx_en_buf = pad_q.tx_en_buf;
    assign ipdrv     = pad_q.ipdrv;
    assign indrv     = pad_q.indrv;
    assign weakp1    = pad_q.weakp1;
    assign weakp0    = pad_q.weakp0;
    assign rx_dat_en = pad_q.rx_dat_en;
    assign rx_clk_en = pad_q.rx_clk_en;

endmodule

// File: tb/tb_itrx_aib_phy_io_buf_ctl.sv
// tb/tb_itrx_aib_phy_io_buf_ctl.sv - directed self-checking bench for the IO buffer controller
module tb_itrx_aib_phy_io_buf_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       por;
    logic [1:0] mode_req;
    logic       tx_data;
    logic [1:0] cfg_pdrv;
    logic [1:0] cfg_ndrv;
    logic       cfg_wkpu;
    logic       cfg_wkpd;

    logic       txdat_mux, tx_en_buf, weakp1, weakp0, rx_dat_en, rx_clk_en, busy;
    logic [1:0] ipdrv, indrv, mode_ack;
    logic       c_txdat_mux, c_tx_en_buf, c_weakp1, c_weakp0, c_rx_dat_en, c_rx_clk_en, c_busy;
    logic [1:0] c_ipdrv, c_indrv, c_mode_ack;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    itrx_aib_phy_io_buf_ctl #(.GUARD(4), .CLK_PIN(1'b0)) dut (
        .clk(clk), .rst(rst), .por(por), .mode_req(mode_req), .tx_data(tx_data),
        .cfg_pdrv(cfg_pdrv), .cfg_ndrv(cfg_ndrv), .cfg_wkpu(cfg_wkpu), .cfg_wkpd(cfg_wkpd),
        .txdat_mux(txdat_mux), .tx_en_buf(tx_en_buf), .ipdrv(ipdrv), .indrv(indrv),
        .weakp1(weakp1), .weakp0(weakp0), .rx_dat_en(rx_dat_en), .rx_clk_en(rx_clk_en),
        .mode_ack(mode_ack), .busy(busy)
    );

    itrx_aib_phy_io_buf_ctl #(.GUARD(4), .CLK_PIN(1'b1)) dut_clk (
        .clk(clk), .rst(rst), .por(por), .mode_req(mode_req), .tx_data(tx_data),
        .cfg_pdrv(cfg_pdrv), .cfg_ndrv(cfg_ndrv), .cfg_wkpu(cfg_wkpu), .cfg_wkpd(cfg_wkpd),
        .txdat_mux(c_txdat_mux), .tx_en_buf(c_tx_en_buf), .ipdrv(c_ipdrv), .indrv(c_indrv),
        .weakp1(c_weakp1), .weakp0(c_weakp0), .rx_dat_en(c_rx_dat_en), .rx_clk_en(c_rx_clk_en),
        .mode_ack(c_mode_ack), .busy(c_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; por = 1'b1; mode_req = 2'b00; tx_data = 1'b0;
        cfg_pdrv = 2'b00; cfg_ndrv = 2'b00; cfg_wkpu = 1'b1; cfg_wkpd = 1'b0;
        step(); step();
        vec++; if (tx_en_buf !== 1'b0) begin errs++; $display("FAIL reset_tx_en: got %b want 0", tx_en_buf); end
        vec++; if ({weakp1, weakp0} !== 2'b01) begin errs++; $display("FAIL reset_weak: got %b want 01", {weakp1, weakp0}); end
        vec++; if ({ipdrv, indrv, mode_ack, busy} !== 7'd0) begin errs++; $display("FAIL reset_misc: got %b want 0", {ipdrv, indrv, mode_ack, busy}); end
        vec++; if ({rx_dat_en, rx_clk_en, txdat_mux} !== 3'b000) begin errs++; $display("FAIL reset_rx: got %b want 000", {rx_dat_en, rx_clk_en, txdat_mux}); end
    endtask

    task automatic test_tx_arm();
        rst = 1'b0; por = 1'b0; cfg_wkpu = 1'b0; cfg_wkpd = 1'b0;
        mode_req = 2'b10; cfg_pdrv = 2'b11; cfg_ndrv = 2'b10;
        for (int i = 0; i < 2; i++) begin
            step();
            vec++; if (busy !== 1'b0) begin errs++; $display("FAIL por_blackout_%0d: busy got %b want 0", i, busy); end
        end
        step();
        cfg_pdrv = 2'b01; cfg_ndrv = 2'b01;
        vec++; if ({busy, tx_en_buf, mode_ack} !== 4'b1000) begin errs++; $display("FAIL arm_entry: got %b want 1000", {busy, tx_en_buf, mode_ack}); end
        vec++; if ({ipdrv, indrv} !== 4'b1110) begin errs++; $display("FAIL arm_drv: got %b want 1110", {ipdrv, indrv}); end
        for (int i = 0; i < 3; i++) begin
            step();
            vec++; if (tx_en_buf !== 1'b0) begin errs++; $display("FAIL arm_guard_%0d: tx_en got %b want 0", i, tx_en_buf); end
        end
        step();
        vec++; if ({tx_en_buf, mode_ack, busy} !== 4'b1100) begin errs++; $display("FAIL tx_entry: got %b want 1100", {tx_en_buf, mode_ack, busy}); end
        vec++; if ({ipdrv, indrv} !== 4'b1110) begin errs++; $display("FAIL tx_drv_latched: got %b want 1110", {ipdrv, indrv}); end
    endtask

    task automatic test_tx_data();
        logic [3:0] pat;
        pat = 4'b1101;
        cfg_wkpu = 1'b1; cfg_wkpd = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tx_data = pat[i];
            step();
            vec++; if (txdat_mux !== pat[i]) begin errs++; $display("FAIL tx_data_%0d: got %b want %b", i, txdat_mux, pat[i]); end
            vec++; if ({weakp1, weakp0} !== 2'b00) begin errs++; $display("FAIL tx_weak_%0d: got %b want 00", i, {weakp1, weakp0}); end
        end
    endtask

    task automatic test_tx_to_rx();
        mode_req = 2'b01; tx_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vec++; if ({busy, tx_en_buf, txdat_mux, rx_dat_en} !== 4'b1000) begin errs++; $display("FAIL quiesce_%0d: got %b want 1000", i, {busy, tx_en_buf, txdat_mux, rx_dat_en}); end
            vec++; if ({ipdrv, weakp0} !== 3'b111) begin errs++; $display("FAIL quiesce_hold_%0d: got %b want 111", i, {ipdrv, weakp0}); end
        end
        step();
        vec++; if ({busy, ipdrv, rx_dat_en, mode_ack} !== 6'd0) begin errs++; $display("FAIL quiesce_off: got %b want 000000", {busy, ipdrv, rx_dat_en, mode_ack}); end
        step();
        vec++; if ({rx_dat_en, tx_en_buf, mode_ack} !== 4'b1001) begin errs++; $display("FAIL rx_entry: got %b want 1001", {rx_dat_en, tx_en_buf, mode_ack}); end
        vec++; if ({c_rx_clk_en, c_rx_dat_en} !== 2'b10) begin errs++; $display("FAIL rx_clk_pin: got %b want 10", {c_rx_clk_en, c_rx_dat_en}); end
    endtask

    task automatic test_abort();
        mode_req = 2'b00;
        step();
        vec++; if ({rx_dat_en, mode_ack} !== 3'b000) begin errs++; $display("FAIL rx_exit: got %b want 000", {rx_dat_en, mode_ack}); end
        mode_req = 2'b10; cfg_pdrv = 2'b10;
        step(); step();
        vec++; if ({busy, ipdrv} !== 3'b110) begin errs++; $display("FAIL abort_arm: got %b want 110", {busy, ipdrv}); end
        mode_req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            vec++; if ({busy, tx_en_buf, ipdrv} !== 4'b0000) begin errs++; $display("FAIL abort_off_%0d: got %b want 0000", i, {busy, tx_en_buf, ipdrv}); end
        end
    endtask

    task automatic test_weak_pulls();
        cfg_wkpu = 1'b1; cfg_wkpd = 1'b1;
        step();
        vec++; if ({weakp1, weakp0} !== 2'b01) begin errs++; $display("FAIL weak_both: got %b want 01", {weakp1, weakp0}); end
        cfg_wkpd = 1'b0;
        step();
        vec++; if ({weakp1, weakp0} !== 2'b10) begin errs++; $display("FAIL weak_up: got %b want 10", {weakp1, weakp0}); end
    endtask

    task automatic test_por_mid_tx();
        mode_req = 2'b10;
        for (int i = 0; i < 5; i++) step();
        vec++; if (tx_en_buf !== 1'b1) begin errs++; $display("FAIL por_pre_tx: got %b want 1", tx_en_buf); end
        por = 1'b1;
        step();
        vec++; if (tx_en_buf !== 1'b1) begin errs++; $display("FAIL por_edge1: got %b want 1", tx_en_buf); end
        step();
        vec++; if ({tx_en_buf, busy, mode_ack, ipdrv} !== 6'd0) begin errs++; $display("FAIL por_safe: got %b want 000000", {tx_en_buf, busy, mode_ack, ipdrv}); end
        vec++; if ({weakp1, weakp0} !== 2'b01) begin errs++; $display("FAIL por_safe_weak: got %b want 01", {weakp1, weakp0}); end
        step(); step();
        por = 1'b0; mode_req = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            vec++; if (rx_dat_en !== 1'b0) begin errs++; $display("FAIL por_release_%0d: rx got %b want 0", i, rx_dat_en); end
        end
        step();
        vec++; if ({rx_dat_en, mode_ack} !== 3'b101) begin errs++; $display("FAIL por_rx_accept: got %b want 101", {rx_dat_en, mode_ack}); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        step();
        vec++; if ({rx_dat_en, weakp1, weakp0, mode_ack} !== 5'b00100) begin errs++; $display("FAIL rst_mid: got %b want 00100", {rx_dat_en, weakp1, weakp0, mode_ack}); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_arm();
        test_tx_data();
        test_tx_to_rx();
        test_abort();
        test_weak_pulls();
        test_por_mid_tx();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && tx_en_buf && (rx_dat_en || rx_clk_en)) begin
            vec++; errs++;
            $display("FAIL tx_rx_overlap: got tx_en=1 rx=%b want no overlap", {rx_dat_en, rx_clk_en});
        end
    end

endmodule
